// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and depth derivation.
package fifo_pkg;

  localparam int ADDRSIZE_DEF = 4;
  localparam int DEPTH        = 1 << ADDRSIZE_DEF;

  // Depth for an arbitrary address width.
  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

  // Width-agnostic: callers zero-extend into 32 bits and truncate the result.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down. Zero upper bits leave narrower values intact.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) b = b ^ (g >> i);
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter for a synchronized pointer.
module gray2bin_conv #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end

endmodule

// File: rtl/wptr_full.sv
// Write-domain pointer, address and status flags for the async FIFO.
module wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE    = 4,
  parameter int AFULL_SLOTS = 2
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wd_rptr,
  output logic                wen,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                wfull_almost,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow
);

  localparam int PW         = ADDRSIZE + 1;
  localparam int FW         = ADDRSIZE + 2;
  localparam int FIFO_DEPTH = depth_of(ADDRSIZE);

  logic [PW-1:0] wbin, wbinnext, wgraynext, rbin_s, level_next;
  logic [FW-1:0] free_next;
  logic          full_next, afull_next;

  gray2bin_conv #(.W(PW)) u_rptr_conv (
    .gray (wd_rptr),
    .bin  (rbin_s)
  );

  // Gated by reset so nothing is written into memory while pointers are cleared.
  assign wen        = winc & ~wfull & wrst;
  assign waddr      = wbin[ADDRSIZE-1:0];
  assign wbinnext   = wbin + PW'(winc & ~wfull);
  assign wgraynext  = PW'(bin2gray(32'(wbinnext)));
  // Full when next write pointer equals the read pointer one lap ahead.
  assign full_next  = (wgraynext == {~wd_rptr[ADDRSIZE:ADDRSIZE-1], wd_rptr[ADDRSIZE-2:0]});
  // Modular subtraction stays correct across pointer wrap.
  assign level_next = wbinnext - rbin_s;
  assign free_next  = FW'(FIFO_DEPTH) - {1'b0, level_next};
  assign afull_next = (free_next <= FW'(AFULL_SLOTS));

  // Pointer and status registers; reset drops pointer state immediately.
  always_ff @(posedge wclk or negedge wrst) begin
    if (!wrst) begin
      wbin         <= '0;
      wptr         <= '0;
      wlevel       <= '0;
      wfull        <= 1'b0;
      wfull_almost <= 1'b0;
      woverflow    <= 1'b0;
    end else begin
      wbin         <= wbinnext;
      wptr         <= wgraynext;
      wlevel       <= level_next;
      wfull        <= full_next;
      wfull_almost <= afull_next;
      woverflow    <= woverflow | (winc & wfull);
    end
  end

  // Gray pointer crossing domains must move by at most one bit per edge.
  a_gray_step: assert property (@(posedge wclk) disable iff (!wrst)
    $countones(wptr ^ $past(wptr)) <= 1);

  // Almost-full covers the full condition.
  a_afull_cover: assert property (@(posedge wclk) disable iff (!wrst)
    wfull |-> wfull_almost);

endmodule

// File: tb/tb_wptr_full.sv
// Directed bench for wptr_full: vector table plus hand-written corner sequences.
module tb_wptr_full;

  logic       wclk = 1'b0;
  logic       wrst, winc;
  logic [4:0] wd_rptr;
  logic       wen, wfull, wfull_almost, woverflow;
  logic [3:0] waddr;
  logic [4:0] wptr, wlevel;

  int n_vec = 0;
  int n_err = 0;

  wptr_full #(.ADDRSIZE(4), .AFULL_SLOTS(2)) dut (
    .wclk         (wclk),
    .wrst         (wrst),
    .winc         (winc),
    .wd_rptr      (wd_rptr),
    .wen          (wen),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .wfull_almost (wfull_almost),
    .wlevel       (wlevel),
    .woverflow    (woverflow)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic       winc;
    logic [4:0] rptr;
    logic       wen;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       full;
    logic       afull;
    logic [4:0] level;
    logic       ovf;
  } vec_t;

  vec_t tbl[20];

  function automatic logic [4:0] g(input int n);
    int m;
    m = n & 31;
    return 5'(m ^ (m >> 1));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_regs(input string tag, input logic [3:0] a, input logic [4:0] p,
                          input logic f, input logic af, input logic [4:0] l, input logic o);
    chk({tag, ".waddr"}, 32'(waddr), 32'(a));
    chk({tag, ".wptr"},  32'(wptr),  32'(p));
    chk({tag, ".wfull"}, 32'(wfull), 32'(f));
    chk({tag, ".afull"}, 32'(wfull_almost), 32'(af));
    chk({tag, ".level"}, 32'(wlevel), 32'(l));
    chk({tag, ".ovf"},   32'(woverflow), 32'(o));
  endtask

  initial begin
    logic [4:0] prev;
    int         lvl;
    wrst = 1'b0; winc = 1'b0; wd_rptr = '0;

    // Power-on reset state.
    #2;
    chk_regs("por", 4'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("por.wen", 32'(wen), 32'd0);
    @(posedge wclk); #2 wrst = 1'b1;
    #1 chk_regs("rel", 4'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    @(posedge wclk); #1;

    // Fill to full, overflow attempts, then one read releases full.
    for (int i = 0; i < 16; i++) begin
      int n;
      n = i + 1;
      tbl[i] = '{1'b1, 5'd0, 1'b1, 4'(n % 16), g(n), (n == 16), (n >= 14), 5'(n), 1'b0};
    end
    for (int i = 16; i < 19; i++)
      tbl[i] = '{1'b1, 5'd0, 1'b0, 4'd0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1};
    tbl[19] = '{1'b0, 5'b00001, 1'b0, 4'd0, 5'b11000, 1'b0, 1'b1, 5'd15, 1'b1};

    for (int i = 0; i < 20; i++) begin
      winc = tbl[i].winc; wd_rptr = tbl[i].rptr;
      #1 chk($sformatf("v%0d.wen", i), 32'(wen), 32'(tbl[i].wen));
      @(posedge wclk); #1;
      chk_regs($sformatf("v%0d", i), tbl[i].waddr, tbl[i].wptr, tbl[i].full,
               tbl[i].afull, tbl[i].level, tbl[i].ovf);
    end

    // Write and read-pointer advance in the same cycle at level 15.
    winc = 1'b1; wd_rptr = g(2);
    #1 chk("sim.wen", 32'(wen), 32'd1);
    @(posedge wclk); #1;
    chk_regs("sim", 4'd1, g(17), 1'b0, 1'b1, 5'd15, 1'b1);

    // Mid-burst reset clears everything asynchronously and blocks writes.
    winc = 1'b1;
    #2 wrst = 1'b0;
    #1 chk_regs("mrst", 4'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("mrst.wen", 32'(wen), 32'd0);
    @(posedge wclk); #1;
    chk_regs("mrst_hold", 4'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("mrst_hold.wen", 32'(wen), 32'd0);
    winc = 1'b0; wd_rptr = '0;
    #2 wrst = 1'b1;
    @(posedge wclk); #1;
    chk_regs("mrst_rel", 4'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);

    // Wrap-around stream with the read pointer trailing by three.
    prev = wptr;
    for (int n = 1; n <= 40; n++) begin
      winc    = 1'b1;
      wd_rptr = (n > 3) ? g(n - 3) : 5'd0;
      @(posedge wclk); #1;
      lvl = (n < 3) ? n : 3;
      chk_regs($sformatf("wrap%0d", n), 4'(n % 16), g(n), 1'b0, 1'b0, 5'(lvl), 1'b0);
      chk($sformatf("wrap%0d.gray_step", n), 32'($countones(wptr ^ prev) <= 1), 32'd1);
      prev = wptr;
    end
    winc = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
